// File: rtl/sdio_cmdhost.sv
// sdio_cmdhost: host SD CMD-line engine, sends one 48-bit command and captures/checks the card reply
module sdio_cmdhost #(
  parameter int NCR_TIMEOUT = 64,
  parameter int LGTIMEOUT   = 7
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ckstb,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [5:0]   i_cmd,
  input  logic [31:0]  i_arg,
  input  logic [1:0]   i_rtype,
  output logic         o_cmd_oe,
  output logic         o_cmd,
  input  logic         i_cmd_in,
  output logic         o_done,
  output logic         o_err,
  output logic [1:0]   o_ercode,
  output logic [5:0]   o_resp,
  output logic [119:0] o_rarg
);
  typedef enum logic [2:0] {IDLE, TX, WAIT, RX, DONE} state_t;
  state_t state, state_nx;
  logic [47:0] tx_sr;
  logic [7:0] cnt;
  logic [LGTIMEOUT-1:0] tcnt;
  logic [1:0] rtype;
  logic [134:0] rx_sr;
  logic [6:0] rx_crc;
  logic [135:0] frame;
  logic [39:0] hdr;
  logic last, in_crc, bad_frame, bad_crc, timeout;
  logic [1:0] code;

  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    return {c[5:3], c[2] ^ c[6] ^ b, c[1:0], c[6] ^ b};
  endfunction

  function automatic logic [6:0] crc_hdr(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc_step(c, d[i]);
    return c;
  endfunction

  assign hdr       = {2'b01, i_cmd, i_arg};
  assign frame     = {rx_sr, i_cmd_in};
  assign last      = cnt == (rtype == 2'd2 ? 8'd135 : 8'd47);
  assign in_crc    = rtype == 2'd2 ? (cnt >= 8'd8 && cnt < 8'd128) : cnt < 8'd40;
  assign bad_frame = ~frame[0] | (rtype == 2'd2 ? frame[135] | frame[134] : frame[47] | frame[46]);
  assign bad_crc   = rtype != 2'd3 && frame[7:1] != rx_crc;
  assign code      = bad_frame ? 2'd3 : bad_crc ? 2'd2 : 2'd0;
  assign timeout   = tcnt == LGTIMEOUT'(NCR_TIMEOUT - 1);

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else state <= state_nx;
  end

  // next state and pad/handshake outputs; everything except accept and DONE exit waits for a strobe
  always_comb begin
    state_nx    = state;
    o_cmd_ready = state == IDLE;
    o_cmd_oe    = state == TX;
    o_cmd       = state != TX || tx_sr[47];
    o_done      = state == DONE;
    o_err       = |o_ercode;
    case (state)
      IDLE:    state_nx = i_cmd_valid ? TX : IDLE;
      TX:      state_nx = i_ckstb && cnt == 8'd47 ? WAIT : TX;
      WAIT:    state_nx = !i_ckstb ? WAIT : (rtype == 2'd0 || (i_cmd_in && timeout)) ? DONE : !i_cmd_in ? RX : WAIT;
      RX:      state_nx = i_ckstb && last ? DONE : RX;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // shifters, counters, running reply CRC and the result registers loaded on entry to DONE
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_sr    <= '0;
      cnt      <= '0;
      tcnt     <= '0;
      rtype    <= '0;
      rx_sr    <= '0;
      rx_crc   <= '0;
      o_ercode <= '0;
      o_resp   <= '0;
      o_rarg   <= '0;
    end else begin
      if (state == IDLE && i_cmd_valid) begin
        tx_sr <= {hdr, crc_hdr(hdr), 1'b1};
        rtype <= i_rtype;
        cnt   <= '0;
        tcnt  <= '0;
      end
      if (i_ckstb && state == TX) begin
        tx_sr <= {tx_sr[46:0], 1'b1};
        cnt   <= cnt + 8'd1;
      end
      if (i_ckstb && state == WAIT) begin
        tcnt   <= tcnt + 1'b1;
        cnt    <= 8'd1;
        rx_sr  <= {rx_sr[133:0], i_cmd_in};
        rx_crc <= '0;
      end
      if (i_ckstb && state == RX) begin
        cnt    <= cnt + 8'd1;
        rx_sr  <= {rx_sr[133:0], i_cmd_in};
        rx_crc <= in_crc ? crc_step(rx_crc, i_cmd_in) : rx_crc;
      end
      if (state != DONE && state_nx == DONE) begin
        o_ercode <= state == RX ? code : rtype == 2'd0 ? 2'd0 : 2'd1;
        if (state == RX) begin
          o_resp <= rtype == 2'd2 ? frame[133:128] : frame[45:40];
          o_rarg <= rtype == 2'd2 ? frame[127:8] : {88'd0, frame[39:8]};
        end
      end
    end
  end
endmodule

// File: tb/tb_sdio_cmdhost.sv
// tb_sdio_cmdhost: scoreboard bench with a card reply model for the SD CMD-line host engine
module tb_sdio_cmdhost;
  localparam int NCR = 64;
  logic i_clk = 0, i_reset = 1, i_ckstb = 0, i_cmd_valid = 0, i_cmd_in = 1;
  logic [5:0] i_cmd = '0;
  logic [31:0] i_arg = '0;
  logic [1:0] i_rtype = '0;
  logic o_cmd_ready, o_cmd_oe, o_cmd, o_done, o_err;
  logic [1:0] o_ercode;
  logic [5:0] o_resp;
  logic [119:0] o_rarg;
  int checks = 0, errors = 0, div = 4, phase = 0, done_cnt = 0;
  typedef struct {logic [1:0] code; logic [5:0] resp; logic [119:0] rarg;} exp_t;
  exp_t sb[$];
  logic [119:0] cid = 120'h03534453553038478012345678010C;

  sdio_cmdhost #(.NCR_TIMEOUT(NCR), .LGTIMEOUT(7)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ckstb(i_ckstb), .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .i_cmd(i_cmd), .i_arg(i_arg), .i_rtype(i_rtype),
    .o_cmd_oe(o_cmd_oe), .o_cmd(o_cmd), .i_cmd_in(i_cmd_in), .o_done(o_done),
    .o_err(o_err), .o_ercode(o_ercode), .o_resp(o_resp), .o_rarg(o_rarg)
  );

  always #5 i_clk = ~i_clk;

  initial forever begin
    @(negedge i_clk);
    phase = (phase + 1) % div;
    i_ckstb = phase == 0;
  end

  initial forever begin
    @(posedge i_clk);
    #1;
    if (o_done) done_cnt++;
  end

  function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
    logic [6:0] c;
    c = '0;
    for (int i = n - 1; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((c[6] ^ d[i]) ? 7'h09 : 7'h00);
    return c;
  endfunction

  function automatic logic [47:0] f48(input logic [39:0] h);
    return {h, crc7({80'd0, h}, 40), 1'b1};
  endfunction

  task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
      input logic [135:0] reply, input int rlen, input int ncr, input int exp_sc,
      input logic [1:0] ecode, input logic [5:0] eresp, input logic [119:0] erarg, output logic [47:0] got);
    logic [39:0] hdr;
    logic [47:0] want;
    int nb, n, bi, guard;
    exp_t e;
    hdr = {2'b01, idx, arg};
    want = f48(hdr);
    sb.push_back('{ecode, eresp, erarg});
    @(negedge i_clk);
    i_cmd = idx; i_arg = arg; i_rtype = rt; i_cmd_valid = 1;
    @(negedge i_clk);
    i_cmd_valid = 0;
    checks++;
    if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL %s ready_drop: got %b want 0", name, o_cmd_ready); end
    got = '0; nb = 0; guard = 0;
    while (nb < 48 && guard < 5000) begin
      #1;
      if (i_ckstb && o_cmd_oe) begin got = {got[46:0], o_cmd}; nb++; end
      @(negedge i_clk);
      guard++;
    end
    checks++;
    if (got !== want) begin errors++; $display("FAIL %s tx_frame: got %h want %h", name, got, want); end
    n = 0; bi = 0; guard = 0;
    @(negedge i_clk);
    #1;
    checks++;
    if (o_cmd_oe !== 1'b0 || o_cmd !== 1'b1) begin errors++; $display("FAIL %s release: oe %b cmd %b want 0 1", name, o_cmd_oe, o_cmd); end
    while (!o_done && guard < 5000) begin
      if (i_ckstb) begin
        n++;
        i_cmd_in = (n > ncr && bi < rlen) ? reply[rlen - 1 - bi] : 1'b1;
        if (n > ncr && bi < rlen) bi++;
      end
      @(negedge i_clk);
      #1;
      guard++;
    end
    i_cmd_in = 1;
    e = sb.pop_front();
    checks++;
    if (!o_done) begin errors++; $display("FAIL %s done_wait: no o_done within %0d cycles", name, guard); end
    else begin
      checks++;
      if (n != exp_sc) begin errors++; $display("FAIL %s strobes_to_done: got %0d want %0d", name, n, exp_sc); end
      checks++;
      if (o_ercode !== e.code || o_err !== (e.code != 2'd0)) begin errors++; $display("FAIL %s ercode: got %0d err %b want %0d", name, o_ercode, o_err, e.code); end
      checks++;
      if (o_resp !== e.resp) begin errors++; $display("FAIL %s resp: got %h want %h", name, o_resp, e.resp); end
      checks++;
      if (o_rarg !== e.rarg) begin errors++; $display("FAIL %s rarg: got %h want %h", name, o_rarg, e.rarg); end
    end
    @(negedge i_clk);
    #1;
    checks++;
    if (o_cmd_ready !== 1'b1 || o_done !== 1'b0) begin errors++; $display("FAIL %s back_idle: ready %b done %b want 1 0", name, o_cmd_ready, o_done); end
  endtask

  task automatic test_reset;
    i_reset = 1;
    repeat (3) @(negedge i_clk);
    #1;
    checks++;
    if ({o_cmd_ready, o_cmd_oe, o_cmd, o_done, o_err, o_ercode} !== 7'b1010000 || o_resp !== 6'd0 || o_rarg !== 120'd0) begin
      errors++;
      $display("FAIL reset_state: ready %b oe %b cmd %b done %b err %b code %0d resp %h rarg %h want 1 0 1 0 0 0 0 0",
        o_cmd_ready, o_cmd_oe, o_cmd, o_done, o_err, o_ercode, o_resp, o_rarg);
    end
    i_reset = 0;
  endtask

  task automatic test_cmd0;
    logic [47:0] got;
    div = 4;
    run_cmd("cmd0", 6'd0, 32'd0, 2'd0, 136'd0, 0, 0, 1, 2'd0, 6'd0, 120'd0, got);
    checks++;
    if (got !== 48'h400000000095) begin errors++; $display("FAIL cmd0_literal: got %h want 400000000095", got); end
  endtask

  task automatic test_r1;
    logic [47:0] got;
    run_cmd("cmd8", 6'd8, 32'h1AA, 2'd1, {88'd0, f48({8'h08, 32'h1AA})}, 48, 2, 50, 2'd0, 6'd8, 120'h1AA, got);
  endtask

  task automatic test_timeout;
    logic [47:0] got;
    run_cmd("cmd7_timeout", 6'd7, 32'h12340000, 2'd1, 136'd0, 0, 0, NCR, 2'd1, 6'd8, 120'h1AA, got);
  endtask

  task automatic test_r3;
    logic [47:0] got;
    run_cmd("acmd41", 6'd41, 32'h40FF8000, 2'd3, {88'd0, 48'h3F80FF8000FF}, 48, 5, 53, 2'd0, 6'h3f, 120'h80FF8000, got);
  endtask

  task automatic test_r2;
    logic [47:0] got;
    logic [135:0] r;
    r = {2'b00, 6'h3f, cid, crc7(cid, 120), 1'b1};
    run_cmd("cmd2", 6'd2, 32'd0, 2'd2, r, 136, 3, 139, 2'd0, 6'h3f, cid, got);
    r[60] = ~r[60];
    run_cmd("cmd2_badcrc", 6'd2, 32'd0, 2'd2, r, 136, 3, 139, 2'd2, 6'h3f, cid ^ (120'd1 << 52), got);
  endtask

  task automatic test_framing;
    logic [47:0] got;
    logic [47:0] r;
    r = f48({8'h08, 32'h1AA});
    r[46] = 1'b1;
    run_cmd("tx_bit_and_crc", 6'd8, 32'h1AA, 2'd1, {88'd0, r}, 48, 1, 49, 2'd3, 6'd8, 120'h1AA, got);
    r = f48({8'h08, 32'h2BB});
    r[0] = 1'b0;
    run_cmd("end_bit", 6'd8, 32'h2BB, 2'd3, {88'd0, r}, 48, 1, 49, 2'd3, 6'd8, 120'h2BB, got);
  endtask

  task automatic test_fast_strobe;
    logic [47:0] got;
    div = 1;
    run_cmd("cmd8_fast", 6'd8, 32'h1AA, 2'd1, {88'd0, f48({8'h08, 32'h1AA})}, 48, 2, 50, 2'd0, 6'd8, 120'h1AA, got);
  endtask

  task automatic test_back_to_back;
    int guard, d0;
    exp_t e;
    d0 = done_cnt;
    repeat (2) sb.push_back('{2'd0, 6'd8, 120'h1AA});
    @(negedge i_clk);
    i_cmd = 6'd0; i_arg = 32'd0; i_rtype = 2'd0; i_cmd_valid = 1;
    guard = 0;
    while (!o_done && guard < 2000) begin @(negedge i_clk); #1; guard++; end
    e = sb.pop_front();
    checks++;
    if (!o_done || o_ercode !== e.code) begin errors++; $display("FAIL b2b_first: done %b code %0d want 1 %0d", o_done, o_ercode, e.code); end
    @(negedge i_clk);
    #1;
    checks++;
    if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap: ready %b want 1", o_cmd_ready); end
    @(negedge i_clk);
    #1;
    checks++;
    if (o_cmd_ready !== 1'b0 || o_cmd_oe !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: ready %b oe %b want 0 1", o_cmd_ready, o_cmd_oe); end
    i_cmd_valid = 0;
    guard = 0;
    while (!o_done && guard < 2000) begin @(negedge i_clk); #1; guard++; end
    e = sb.pop_front();
    checks++;
    if (!o_done || o_ercode !== e.code || o_resp !== e.resp) begin errors++; $display("FAIL b2b_second: done %b code %0d resp %h want 1 %0d %h", o_done, o_ercode, o_resp, e.code, e.resp); end
    @(negedge i_clk);
    #1;
    checks++;
    if (done_cnt != d0 + 2) begin errors++; $display("FAIL b2b_done_count: got %0d want %0d", done_cnt - d0, 2); end
  endtask

  task automatic test_reset_midframe;
    int nb, guard, d0;
    logic [47:0] got;
    div = 4;
    @(negedge i_clk);
    i_cmd = 6'd0; i_arg = 32'hFFFF0000; i_rtype = 2'd1; i_cmd_valid = 1;
    @(negedge i_clk);
    i_cmd_valid = 0;
    nb = 0; guard = 0;
    while (nb < 20 && guard < 2000) begin
      #1;
      if (i_ckstb && o_cmd_oe) nb++;
      @(negedge i_clk);
      guard++;
    end
    d0 = done_cnt;
    i_reset = 1;
    @(negedge i_clk);
    #1;
    checks++;
    if (o_cmd_oe !== 1'b0 || o_cmd !== 1'b1 || o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort: oe %b cmd %b ready %b want 0 1 1", o_cmd_oe, o_cmd, o_cmd_ready);
    end
    i_reset = 0;
    repeat (300) @(negedge i_clk);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL reset_no_done: got %0d pulses want 0", done_cnt - d0); end
    run_cmd("cmd0_after_reset", 6'd0, 32'd0, 2'd0, 136'd0, 0, 0, 1, 2'd0, 6'd0, 120'd0, got);
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_r1();
    test_timeout();
    test_r3();
    test_r2();
    test_framing();
    test_fast_strobe();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
